// File: rtl/dot_eater.sv
// Game-side dot eater: queries the dot map on every new Pac-Man tile, clears eaten dots,
// keeps score and eaten-dot count, and sequences the dot map restore between levels.
module dot_eater #(
  parameter int DOT_POINTS     = 10,
  parameter int POWER_POINTS   = 50,
  parameter int TOTAL_DOTS     = 240,
  parameter int RESTORE_CYCLES = 1009,
  parameter int SCORE_W        = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [4:0]         pac_tile_x,
  input  logic [5:0]         pac_tile_y,
  input  logic               pac_valid,
  input  logic               level_start,
  input  logic               game_reset,
  input  logic               has_dot,
  input  logic               is_wall_tile,
  input  logic               is_power_tile,
  output logic [4:0]         query_tile_x,
  output logic [5:0]         query_tile_y,
  output logic               clear_dot,
  output logic               level_reset,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         dots_eaten,
  output logic               dot_eaten_pulse,
  output logic               power_eaten_pulse,
  output logic               level_clear,
  output logic               busy
);

  localparam int CNT_W = $clog2(RESTORE_CYCLES + 1);
  localparam logic [31:0] SCORE_MAX = 32'((64'd1 << SCORE_W) - 64'd1);

  typedef enum logic [1:0] {IDLE, RESTORE, QUERY, CLEAR} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [4:0]         last_x;
  logic [5:0]         last_y;
  logic               last_valid;
  logic               power_hit;
  logic               restart;
  logic               tile_ok;
  logic               accept;
  logic               eat;
  logic [31:0]        score_sum;
  logic [SCORE_W-1:0] score_next;
  logic [7:0]         dots_next;

  assign restart = level_start | game_reset;
  assign tile_ok = (pac_tile_x <= 5'd27) && (pac_tile_y <= 6'd35);
  // A restart on the CLEAR edge wins, so an aborted clear never reaches the outputs.
  assign eat     = !restart && (state == CLEAR);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    if (restart) begin
      state_next = RESTORE;
      cnt_next   = CNT_W'(RESTORE_CYCLES);
    end else begin
      case (state)
        IDLE: begin
          if (pac_valid && !level_clear && tile_ok &&
              (!last_valid || pac_tile_x != last_x || pac_tile_y != last_y)) begin
            accept     = 1'b1;
            state_next = QUERY;
          end
        end
        RESTORE: begin
          if (cnt <= CNT_W'(1)) state_next = IDLE;
          else                  cnt_next   = cnt - CNT_W'(1);
        end
        QUERY:   state_next = (has_dot && !is_wall_tile) ? CLEAR : IDLE;
        CLEAR:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    score_sum  = 32'(score) + (power_hit ? 32'(POWER_POINTS) : 32'(DOT_POINTS));
    score_next = (score_sum > SCORE_MAX) ? SCORE_MAX[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
    dots_next  = (dots_eaten == 8'd255) ? 8'd255 : dots_eaten + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      last_x            <= '0;
      last_y            <= '0;
      last_valid        <= 1'b0;
      power_hit         <= 1'b0;
      query_tile_x      <= '0;
      query_tile_y      <= '0;
      clear_dot         <= 1'b0;
      level_reset       <= 1'b0;
      score             <= '0;
      dots_eaten        <= '0;
      dot_eaten_pulse   <= 1'b0;
      power_eaten_pulse <= 1'b0;
      level_clear       <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_next;
      cnt               <= cnt_next;
      busy              <= (state_next != IDLE);
      level_reset       <= (state_next == RESTORE);
      clear_dot         <= eat;
      dot_eaten_pulse   <= eat && !power_hit;
      power_eaten_pulse <= eat && power_hit;
      if (state == QUERY) power_hit <= is_power_tile;
      if (accept) begin
        query_tile_x <= pac_tile_x;
        query_tile_y <= pac_tile_y;
        last_x       <= pac_tile_x;
        last_y       <= pac_tile_y;
        last_valid   <= 1'b1;
      end
      if (restart) begin
        dots_eaten  <= '0;
        level_clear <= 1'b0;
        last_valid  <= 1'b0;
        if (game_reset) score <= '0;
      end else if (eat) begin
        score      <= score_next;
        dots_eaten <= dots_next;
        if (int'(dots_next) >= TOTAL_DOTS) level_clear <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dot_eater.sv
// Directed bench for dot_eater with a cycle-level reference model of the query/clear protocol.
module tb_dot_eater;
  localparam int RC = 1009;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] px = '0;
  logic [5:0] py = '0;
  logic pv = 0, ls = 0, gr = 0, hd = 0, wl = 0, pw = 0;

  logic [4:0]  qx, qx4;
  logic [5:0]  qy, qy4;
  logic        cd, lr, dp, pp, lc, bz;
  logic        cd4, lr4, dp4, pp4, lc4, bz4;
  logic [19:0] sc;
  logic [3:0]  sc4;
  logic [7:0]  de, de4;

  dot_eater dut (
    .clk(clk), .rst_n(rst_n), .pac_tile_x(px), .pac_tile_y(py), .pac_valid(pv),
    .level_start(ls), .game_reset(gr), .has_dot(hd), .is_wall_tile(wl), .is_power_tile(pw),
    .query_tile_x(qx), .query_tile_y(qy), .clear_dot(cd), .level_reset(lr), .score(sc),
    .dots_eaten(de), .dot_eaten_pulse(dp), .power_eaten_pulse(pp), .level_clear(lc), .busy(bz)
  );

  dot_eater #(.SCORE_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .pac_tile_x(px), .pac_tile_y(py), .pac_valid(pv),
    .level_start(ls), .game_reset(gr), .has_dot(hd), .is_wall_tile(wl), .is_power_tile(pw),
    .query_tile_x(qx4), .query_tile_y(qy4), .clear_dot(cd4), .level_reset(lr4), .score(sc4),
    .dots_eaten(de4), .dot_eaten_pulse(dp4), .power_eaten_pulse(pp4), .level_clear(lc4), .busy(bz4)
  );

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: a new tile accepted at edge T shows its clear at T+2; restores block for RC edges.
  int m_score = 0, m_dots = 0, m_restore = 0;
  bit m_lc = 0, m_lv = 0, p1 = 0, p2 = 0, p2_pow = 0, m_clr = 0, m_dp = 0, m_pp = 0;
  int m_lx = 0, m_ly = 0, m_qx = 0, m_qy = 0;

  always @(posedge clk or negedge rst_n) begin
    bit nxt2, start;
    if (!rst_n) begin
      m_score = 0; m_dots = 0; m_restore = 0; m_lc = 0; m_lv = 0;
      p1 = 0; p2 = 0; p2_pow = 0; m_clr = 0; m_dp = 0; m_pp = 0;
      m_lx = 0; m_ly = 0; m_qx = 0; m_qy = 0;
    end else if (ls || gr) begin
      p1 = 0; p2 = 0; m_clr = 0; m_dp = 0; m_pp = 0;
      m_dots = 0; m_lc = 0; m_lv = 0;
      if (gr) m_score = 0;
      m_restore = RC;
    end else begin
      m_clr = p2; m_dp = p2 && !p2_pow; m_pp = p2 && p2_pow;
      if (p2) begin
        m_score += p2_pow ? 50 : 10;
        if (m_dots < 255) m_dots++;
        if (m_dots >= 240) m_lc = 1;
      end
      nxt2 = p1 && hd && !wl;
      if (p1) p2_pow = pw;
      start = (m_restore == 0) && !p1 && !p2 && pv && !m_lc && px <= 27 && py <= 35 &&
              (!m_lv || int'(px) != m_lx || int'(py) != m_ly);
      if (m_restore > 0) m_restore--;
      p2 = nxt2;
      p1 = start;
      if (start) begin
        m_lv = 1; m_lx = int'(px); m_ly = int'(py); m_qx = int'(px); m_qy = int'(py);
      end
    end
  end

  always @(negedge clk) begin
    check("clear_dot", cd, m_clr);
    check("dot_pulse", dp, m_dp);
    check("power_pulse", pp, m_pp);
    check("level_reset", lr, m_restore > 0);
    check("busy", bz, (m_restore > 0) || p1 || p2);
    check("score", sc, (m_score > 1048575) ? 1048575 : m_score);
    check("score4", sc4, (m_score > 15) ? 15 : m_score);
    check("dots_eaten", de, m_dots);
    check("level_clear", lc, m_lc);
    if (p1 || p2 || m_clr) begin
      check("query_x", qx, m_qx);
      check("query_y", qy, m_qy);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic move(input int x, input int y, input bit dot, input bit wall, input bit pow);
    px = 5'(x); py = 6'(y); hd = dot; wl = wall; pw = pow; pv = 1;
    tick(4);
  endtask

  task automatic pulse_start(input bit g);
    ls = !g; gr = g;
    tick(1);
    ls = 0; gr = 0;
  endtask

  task automatic wait_restore(input int exp_len);
    int n;
    n = 0;
    while (lr && n < 3000) begin n++; tick(1); end
    check("restore_len", n, exp_len);
  endtask

  int cnt;

  initial begin
    // 1: reset values, then a full restore
    tick(3);
    check("rst_score", sc, 0);
    check("rst_busy", bz, 0);
    check("rst_level_reset", lr, 0);
    rst_n = 1;
    tick(2);
    pulse_start(0);
    check("restore_busy", bz, 1);
    wait_restore(RC);

    // 2: normal dot at (1,4), latency T+2
    px = 5'd1; py = 6'd4; hd = 1; wl = 0; pw = 0; pv = 1;
    tick(2);
    check("lat_before", cd, 0);
    tick(1);
    check("lat_clear", cd, 1);
    check("lat_qx", qx, 1);
    check("lat_qy", qy, 4);
    check("lat_dot_pulse", dp, 1);
    tick(1);
    check("lat_after", cd, 0);
    check("score_dot", sc, 10);
    check("dots_1", de, 1);

    // 3: power pellet, narrow score saturates
    move(1, 6, 1, 0, 1);
    check("score_power", sc, 60);
    check("score4_sat", sc4, 15);

    // 4: no dot, wall, stationary, out-of-range, pac not valid
    move(2, 4, 0, 0, 0);
    move(3, 4, 1, 1, 0);
    check("score_nodot", sc, 60);
    px = 5'd1; py = 6'd4; hd = 1; wl = 0; pw = 0;
    cnt = 0;
    repeat (100) begin tick(1); cnt += int'(cd); end
    check("stationary_queries", cnt, 1);
    check("score_back", sc, 70);
    px = 5'd28; py = 6'd5;
    cnt = 0;
    repeat (10) begin tick(1); cnt += int'(bz); end
    check("out_of_range", cnt, 0);
    pv = 0; px = 5'd5; py = 6'd5;
    cnt = 0;
    repeat (10) begin tick(1); cnt += int'(bz); end
    check("pac_invalid", cnt, 0);

    // 5: clear the level
    for (int i = 0; i < 237; i++) move(i % 28, 10 + i / 28, 1, 0, 0);
    check("lvl_dots", de, 240);
    check("lvl_clear", lc, 1);
    check("lvl_score", sc, 2440);
    px = 5'd20; py = 6'd20;
    cnt = 0;
    repeat (8) begin tick(1); cnt += int'(cd); end
    check("after_clear_no_eat", cnt, 0);
    pulse_start(0);
    check("ls_level_clear", lc, 0);
    check("ls_dots", de, 0);
    check("ls_score_kept", sc, 2440);
    wait_restore(RC);
    tick(4);
    check("forced_requery", sc, 2450);

    // 6: abort during QUERY, reload during RESTORE, game reset
    px = 5'd21; py = 6'd20;
    tick(1);
    ls = 1;
    tick(1);
    ls = 0;
    check("abort_lr", lr, 1);
    check("abort_cd", cd, 0);
    tick(500);
    check("abort_score", sc, 2450);
    pulse_start(0);
    wait_restore(RC);
    tick(4);
    pulse_start(1);
    check("gr_score", sc, 0);
    wait_restore(RC);
    tick(4);
    check("gr_eat", sc, 10);
    check("gr_eat4", sc4, 10);

    // async reset mid-query
    px = 5'd7; py = 6'd7;
    tick(1);
    rst_n = 0;
    #1;
    check("async_busy", bz, 0);
    check("async_score", sc, 0);
    tick(2);
    rst_n = 1;
    tick(6);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
